// File: rtl/fp32_mult_top_if.sv
// Operand/result bundle for the FP32 multiplier: two operands in, product, flags and reference product out.
// The multiplier has no handshake; these signals are sampled and driven every clock.
interface fp32_mult_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic [7:0]  status;
    logic [31:0] z_function_out;

    modport master (
        output a,
        output b,
        input  z,
        input  status,
        input  z_function_out
    );

    modport slave (
        input  a,
        input  b,
        output z,
        output status,
        output z_function_out
    );
endinterface

// File: rtl/fp32_mult_top.sv
// Pipelined IEEE-754 single multiplier, 2-cycle latency, one operation per clock, never stalls.
// Denormals flush to signed zero and NaN operands act as infinity; a reference function path runs alongside.
package fp32_mult_pkg;
    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away_zero = 3'd5
    } round_values;

    function automatic logic [31:0] fp_mult(input logic [31:0] a, input logic [31:0] b,
                                            input round_values rnd);
        logic        sgn;
        int          e;
        logic [47:0] ma;
        logic [47:0] mb;
        logic [47:0] p;
        logic [23:0] sig;
        logic [24:0] sum;
        logic        g;
        logic        s;
        logic        up;
        sgn = a[31] ^ b[31];
        if ((a[30:23] == 8'h00 && b[30:23] == 8'hFF) || (a[30:23] == 8'hFF && b[30:23] == 8'h00))
            return 32'h7FC00000;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
            return {sgn, 8'hFF, 23'd0};
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00)
            return {sgn, 31'd0};
        ma = {24'd0, 1'b1, a[22:0]};
        mb = {24'd0, 1'b1, b[22:0]};
        p  = ma * mb;
        e  = int'({24'd0, a[30:23]}) + int'({24'd0, b[30:23]}) - 127;
        if (p[47]) begin
            sig = p[47:24];
            g   = p[23];
            s   = |p[22:0];
            e   = e + 1;
        end else begin
            sig = p[46:23];
            g   = p[22];
            s   = |p[21:0];
        end
        case (rnd)
            IEEE_near: up = g & (s | sig[0]);
            IEEE_zero: up = 1'b0;
            IEEE_pinf: up = (g | s) & ~sgn;
            IEEE_ninf: up = (g | s) & sgn;
            near_up:   up = g & (s | ~sgn);
            default:   up = g | s;
        endcase
        sum = {1'b0, sig} + {24'd0, up};
        if (sum[24]) begin
            sig = sum[24:1];
            e   = e + 1;
        end else begin
            sig = sum[23:0];
        end
        if (e >= 255) begin
            if (rnd == IEEE_near || rnd == near_up || rnd == away_zero ||
                (rnd == IEEE_pinf && !sgn) || (rnd == IEEE_ninf && sgn))
                return {sgn, 8'hFF, 23'd0};
            return {sgn, 31'h7F7FFFFF};
        end
        if (e <= 0) begin
            if (rnd == away_zero || (rnd == IEEE_pinf && !sgn) || (rnd == IEEE_ninf && sgn))
                return {sgn, 31'h00800000};
            return {sgn, 31'd0};
        end
        return {sgn, e[7:0], sig[22:0]};
    endfunction
endpackage

module fp32_mult_top #(
    parameter fp32_mult_pkg::round_values rnd = fp32_mult_pkg::IEEE_near
) (
    input  logic       clk,
    input  logic       rst,
    fp32_mult_if.slave bus
);
    import fp32_mult_pkg::*;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_z;
    logic [31:0] r_z_fn;
    logic [7:0]  r_status;

    logic        w_sign;
    logic        w_a_zero;
    logic        w_b_zero;
    logic        w_a_inf;
    logic        w_b_inf;
    logic        w_nan;
    logic        w_inf;
    logic        w_zero;
    logic [47:0] w_man_a;
    logic [47:0] w_man_b;
    logic [47:0] w_prod;
    logic [9:0]  w_exp_sum;
    logic [9:0]  w_exp_norm;
    logic [9:0]  w_exp_rnd;
    logic [23:0] w_sig;
    logic [24:0] w_sig_sum;
    logic [22:0] w_frac_rnd;
    logic        w_guard;
    logic        w_sticky;
    logic        w_inexact;
    logic        w_inc;
    logic        w_ovf;
    logic        w_unf;
    logic        w_ovf_to_inf;
    logic        w_unf_to_min;
    logic [31:0] w_z;
    logic        w_f_zero;
    logic        w_f_inf;
    logic        w_f_nan;
    logic        w_f_tiny;
    logic        w_f_huge;
    logic        w_f_inexact;
    logic [7:0]  w_status;

    // Operand classification: exponent field alone decides zero/inf.
    assign w_sign   = r_a[31] ^ r_b[31];
    assign w_a_zero = (r_a[30:23] == 8'h00);
    assign w_b_zero = (r_b[30:23] == 8'h00);
    assign w_a_inf  = (r_a[30:23] == 8'hFF);
    assign w_b_inf  = (r_b[30:23] == 8'hFF);
    assign w_nan    = (w_a_zero & w_b_inf) | (w_a_inf & w_b_zero);
    assign w_inf    = (w_a_inf | w_b_inf) & ~w_nan;
    assign w_zero   = (w_a_zero | w_b_zero) & ~w_nan;

    assign w_man_a    = {24'd0, 1'b1, r_a[22:0]};
    assign w_man_b    = {24'd0, 1'b1, r_b[22:0]};
    assign w_prod     = w_man_a * w_man_b;
    assign w_exp_sum  = {2'b00, r_a[30:23]} + {2'b00, r_b[30:23]} - 10'd127;
    assign w_exp_norm = w_exp_sum + {9'd0, w_prod[47]};
    assign w_sig      = w_prod[47] ? w_prod[47:24] : w_prod[46:23];
    assign w_guard    = w_prod[47] ? w_prod[23] : w_prod[22];
    assign w_sticky   = w_prod[47] ? (|w_prod[22:0]) : (|w_prod[21:0]);
    assign w_inexact  = w_guard | w_sticky;

    always_comb begin
        w_inc = 1'b0;
        case (rnd)
            IEEE_near: w_inc = w_guard & (w_sticky | w_sig[0]);
            IEEE_zero: w_inc = 1'b0;
            IEEE_pinf: w_inc = w_inexact & ~w_sign;
            IEEE_ninf: w_inc = w_inexact & w_sign;
            near_up:   w_inc = w_guard & (w_sticky | ~w_sign);
            away_zero: w_inc = w_inexact;
            default:   w_inc = 1'b0;
        endcase
    end

    // A carry out of the rounded significand renormalises by one place.
    assign w_sig_sum  = {1'b0, w_sig} + {24'd0, w_inc};
    assign w_frac_rnd = w_sig_sum[24] ? w_sig_sum[23:1] : w_sig_sum[22:0];
    assign w_exp_rnd  = w_exp_norm + {9'd0, w_sig_sum[24]};
    assign w_ovf      = ($signed(w_exp_rnd) >= 10'sd255);
    assign w_unf      = ($signed(w_exp_rnd) <= 10'sd0);

    assign w_ovf_to_inf = (rnd == IEEE_near) | (rnd == near_up) | (rnd == away_zero) |
                          ((rnd == IEEE_pinf) & ~w_sign) | ((rnd == IEEE_ninf) & w_sign);
    assign w_unf_to_min = (rnd == away_zero) |
                          ((rnd == IEEE_pinf) & ~w_sign) | ((rnd == IEEE_ninf) & w_sign);

    always_comb begin
        w_z         = {w_sign, w_exp_rnd[7:0], w_frac_rnd};
        w_f_zero    = 1'b0;
        w_f_inf     = 1'b0;
        w_f_nan     = 1'b0;
        w_f_tiny    = 1'b0;
        w_f_huge    = 1'b0;
        w_f_inexact = w_inexact;
        if (w_nan) begin
            w_z         = 32'h7FC00000;
            w_f_nan     = 1'b1;
            w_f_inexact = 1'b0;
        end else if (w_inf) begin
            w_z         = {w_sign, 8'hFF, 23'd0};
            w_f_inf     = 1'b1;
            w_f_inexact = 1'b0;
        end else if (w_zero) begin
            w_z         = {w_sign, 31'd0};
            w_f_zero    = 1'b1;
            w_f_inexact = 1'b0;
        end else if (w_ovf) begin
            w_f_huge    = 1'b1;
            w_f_inexact = 1'b1;
            w_f_inf     = w_ovf_to_inf;
            w_z         = w_ovf_to_inf ? {w_sign, 8'hFF, 23'd0} : {w_sign, 31'h7F7FFFFF};
        end else if (w_unf) begin
            w_f_tiny    = 1'b1;
            w_f_inexact = 1'b1;
            w_f_zero    = ~w_unf_to_min;
            w_z         = w_unf_to_min ? {w_sign, 31'h00800000} : {w_sign, 31'd0};
        end
        w_status = {2'b00, w_f_inexact, w_f_huge, w_f_tiny, w_f_nan, w_f_inf, w_f_zero};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_z      <= '0;
            r_status <= '0;
            r_z_fn   <= '0;
        end else begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_z      <= w_z;
            r_status <= w_status;
            r_z_fn   <= fp_mult(r_a, r_b, rnd);
        end
    end

    assign bus.z              = r_z;
    assign bus.status         = r_status;
    assign bus.z_function_out = r_z_fn;
endmodule

// File: tb/tb_fp32_mult_top.sv
// Directed bench for fp32_mult_top: one instance per rounding mode, all fed the same operands.
module tb_fp32_mult_top;
    import fp32_mult_pkg::*;

    localparam int NM = 6;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic [31:0] tb_a = '0;
    logic [31:0] tb_b = '0;
    logic [31:0] z_m  [NM];
    logic [7:0]  st_m [NM];
    logic [31:0] zf_m [NM];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NM; g++) begin : g_dut
        fp32_mult_if u_bus ();
        assign u_bus.a  = tb_a;
        assign u_bus.b  = tb_b;
        assign z_m[g]   = u_bus.z;
        assign st_m[g]  = u_bus.status;
        assign zf_m[g]  = u_bus.z_function_out;
        fp32_mult_top #(.rnd(round_values'(3'(g)))) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_bus)
        );
    end

    // Columns: IEEE_near, IEEE_zero, IEEE_pinf, IEEE_ninf, near_up, away_zero.
    localparam logic [31:0] RND_A [6] = '{32'h3F800001, 32'h3F800001, 32'hBF800001,
                                          32'h3F800003, 32'h3F918E00, 32'h3FC00000};
    localparam logic [31:0] RND_B [6] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00000,
                                          32'h3FC00000, 32'h3FE12000, 32'h3FC00000};
    localparam logic [31:0] RND_Z [6][6] = '{
        '{32'h3F800002, 32'h3F800002, 32'h3F800003, 32'h3F800002, 32'h3F800002, 32'h3F800003},
        '{32'h3FC00002, 32'h3FC00001, 32'h3FC00002, 32'h3FC00001, 32'h3FC00002, 32'h3FC00002},
        '{32'hBFC00002, 32'hBFC00001, 32'hBFC00001, 32'hBFC00002, 32'hBFC00001, 32'hBFC00002},
        '{32'h3FC00004, 32'h3FC00004, 32'h3FC00005, 32'h3FC00004, 32'h3FC00005, 32'h3FC00005},
        '{32'h40000000, 32'h3FFFFFFF, 32'h40000000, 32'h3FFFFFFF, 32'h40000000, 32'h40000000},
        '{32'h40100000, 32'h40100000, 32'h40100000, 32'h40100000, 32'h40100000, 32'h40100000}};
    localparam logic [7:0] RND_S [6] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h00};

    localparam logic [31:0] EXT_A [4] = '{32'h7F000000, 32'hFF000000, 32'h00800000, 32'h80800000};
    localparam logic [31:0] EXT_B [4] = '{32'h7F000000, 32'h7F000000, 32'h00800000, 32'h00800000};
    localparam logic [31:0] EXT_Z [4][6] = '{
        '{32'h7F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800000},
        '{32'hFF800000, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 32'hFF800000, 32'hFF800000},
        '{32'h00000000, 32'h00000000, 32'h00800000, 32'h00000000, 32'h00000000, 32'h00800000},
        '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80800000, 32'h80000000, 32'h80800000}};
    localparam logic [7:0] EXT_S [4][6] = '{
        '{8'h32, 8'h30, 8'h32, 8'h30, 8'h32, 8'h32},
        '{8'h32, 8'h30, 8'h30, 8'h32, 8'h32, 8'h32},
        '{8'h29, 8'h29, 8'h28, 8'h29, 8'h29, 8'h28},
        '{8'h29, 8'h29, 8'h29, 8'h28, 8'h29, 8'h28}};

    // +NaN, -NaN, +inf, -inf, +normal, -normal, +denormal, -denormal, +0, -0; class 2=inf, 1=normal, 0=zero.
    localparam logic [31:0] GRID_V [10] = '{32'h7FC00000, 32'hFFC00000, 32'h7F800000, 32'hFF800000,
                                            32'h3F2A0000, 32'hBF214000, 32'h00400000, 32'h80400000,
                                            32'h00000000, 32'h80000000};
    localparam int GRID_C [10] = '{2, 2, 2, 2, 1, 1, 0, 0, 0, 0};

    task automatic drive_and_wait(input logic [31:0] x, input logic [31:0] y);
        tb_a = x;
        tb_b = y;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tb_a = $urandom();
            tb_b = $urandom();
            @(posedge clk);
            #1;
            for (int m = 0; m < NM; m++) begin
                n_tests++;
                if (z_m[m] !== 32'h0 || st_m[m] !== 8'h0 || zf_m[m] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL reset_hold mode=%0d z=%h st=%h zf=%h, want 00000000/00/00000000",
                             m, z_m[m], st_m[m], zf_m[m]);
                end
            end
        end
        tb_a = 32'h3F000000;
        tb_b = 32'h40000000;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (z_m[0] !== 32'h0 || st_m[0] !== 8'h01) begin
            n_fail++;
            $display("FAIL first_edge z=%h st=%h, want 00000000/01", z_m[0], st_m[0]);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (z_m[0] !== 32'h3F800000 || st_m[0] !== 8'h00 || zf_m[0] !== 32'h3F800000) begin
            n_fail++;
            $display("FAIL half_times_two z=%h st=%h zf=%h, want 3f800000/00", z_m[0], st_m[0], zf_m[0]);
        end
    endtask

    task automatic test_rounding();
        for (int v = 0; v < 6; v++) begin
            drive_and_wait(RND_A[v], RND_B[v]);
            for (int m = 0; m < NM; m++) begin
                n_tests++;
                if (z_m[m] !== RND_Z[v][m] || st_m[m] !== RND_S[v] || zf_m[m] !== RND_Z[v][m]) begin
                    n_fail++;
                    $display("FAIL rounding vec=%0d mode=%0d z=%h st=%h zf=%h, want %h/%h",
                             v, m, z_m[m], st_m[m], zf_m[m], RND_Z[v][m], RND_S[v]);
                end
            end
        end
    endtask

    task automatic test_over_underflow();
        for (int v = 0; v < 4; v++) begin
            drive_and_wait(EXT_A[v], EXT_B[v]);
            for (int m = 0; m < NM; m++) begin
                n_tests++;
                if (z_m[m] !== EXT_Z[v][m] || st_m[m] !== EXT_S[v][m] || zf_m[m] !== EXT_Z[v][m]) begin
                    n_fail++;
                    $display("FAIL range vec=%0d mode=%0d z=%h st=%h zf=%h, want %h/%h",
                             v, m, z_m[m], st_m[m], zf_m[m], EXT_Z[v][m], EXT_S[v][m]);
                end
            end
        end
    endtask

    task automatic test_exception_grid();
        logic [31:0] ez;
        logic [7:0]  es;
        logic        s;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 10; j++) begin
                s = GRID_V[i][31] ^ GRID_V[j][31];
                if ((GRID_C[i] == 0 && GRID_C[j] == 2) || (GRID_C[i] == 2 && GRID_C[j] == 0)) begin
                    ez = 32'h7FC00000; es = 8'h04;
                end else if (GRID_C[i] == 2 || GRID_C[j] == 2) begin
                    ez = {s, 8'hFF, 23'd0}; es = 8'h02;
                end else if (GRID_C[i] == 0 || GRID_C[j] == 0) begin
                    ez = {s, 31'd0}; es = 8'h01;
                end else if (i != j) begin
                    ez = 32'hBED62900; es = 8'h00;
                end else begin
                    ez = (i == 4) ? 32'h3EE1C800 : 32'h3ECB2320; es = 8'h00;
                end
                drive_and_wait(GRID_V[i], GRID_V[j]);
                for (int m = 0; m < NM; m++) begin
                    n_tests++;
                    if (z_m[m] !== ez || st_m[m] !== es || zf_m[m] !== ez) begin
                        n_fail++;
                        $display("FAIL grid a=%h b=%h mode=%0d z=%h st=%h zf=%h, want %h/%h",
                                 GRID_V[i], GRID_V[j], m, z_m[m], st_m[m], zf_m[m], ez, es);
                    end
                end
            end
        end
    endtask

    task automatic test_midstream_reset();
        tb_a = 32'h7F000000;
        tb_b = 32'h7F000000;
        @(posedge clk);
        #1;
        tb_a = 32'h3FC00000;
        tb_b = 32'h3FC00000;
        @(posedge clk);
        #1;
        n_tests++;
        if (z_m[0] !== 32'h7F800000) begin
            n_fail++;
            $display("FAIL inflight_before_reset z=%h, want 7f800000", z_m[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            for (int m = 0; m < NM; m++) begin
                n_tests++;
                if (z_m[m] !== 32'h0 || st_m[m] !== 8'h0 || zf_m[m] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL midstream_reset step=%0d mode=%0d z=%h st=%h zf=%h, want zeros",
                             k, m, z_m[m], st_m[m], zf_m[m]);
                end
            end
            @(posedge clk);
        end
        tb_a = 32'h3F000000;
        tb_b = 32'h40000000;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (z_m[0] !== 32'h0 || st_m[0] !== 8'h01) begin
            n_fail++;
            $display("FAIL discard_inflight z=%h st=%h, want 00000000/01", z_m[0], st_m[0]);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (z_m[0] !== 32'h3F800000 || st_m[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL after_reset_op z=%h st=%h, want 3f800000/00", z_m[0], st_m[0]);
        end
    endtask

    task automatic test_back_to_back();
        int n_print = 0;
        for (int i = 0; i <= 6; i++) begin
            tb_a = (i < 6) ? RND_A[i] : 32'h0;
            tb_b = (i < 6) ? RND_B[i] : 32'h0;
            @(posedge clk);
            #1;
            if (i >= 1) begin
                for (int m = 0; m < NM; m++) begin
                    n_tests++;
                    if (z_m[m] !== RND_Z[i-1][m] || st_m[m] !== RND_S[i-1]) begin
                        n_fail++;
                        $display("FAIL b2b_directed vec=%0d mode=%0d z=%h st=%h, want %h/%h",
                                 i - 1, m, z_m[m], st_m[m], RND_Z[i-1][m], RND_S[i-1]);
                    end
                end
            end
        end
        for (int c = 0; c < 10000; c++) begin
            tb_a = $urandom();
            tb_b = $urandom();
            @(posedge clk);
            #1;
            for (int m = 0; m < NM; m++) begin
                n_tests++;
                if (z_m[m] !== zf_m[m]) begin
                    n_fail++;
                    if (n_print < 20) begin
                        n_print++;
                        $display("FAIL b2b_random t=%0t mode=%0d z=%h z_function_out=%h",
                                 $time, m, z_m[m], zf_m[m]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_over_underflow();
        test_exception_grid();
        test_midstream_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fp32_mult_top.md
# fp32_mult_top

Pipelined IEEE-754 single-precision floating-point multiplier with a compile-time rounding mode, an 8-bit exception status byte, and a built-in golden-model output path. It is the top-level arithmetic wrapper of the FP multiplier subsystem. Each clock it accepts two 32-bit operands and delivers the rounded product, status flags and the reference-function product two cycles later.

## Interface
- `rnd`, default `IEEE_near`: rounding mode from enum `round_values` = {IEEE_near=0, IEEE_zero=1, IEEE_pinf=2, IEEE_ninf=3, near_up=4, away_zero=5}.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  Active-low, asynchronous reset (the single clock is `clk`).
- `a`  in  32  operand A, IEEE-754 single.
- `b`  in  32  operand B, IEEE-754 single.
- `z`  out  32  rounded product from the RTL datapath.
- `status`  out  8  exception flags: [0] zero, [1] inf, [2] nan, [3] tiny, [4] huge, [5] inexact, [7:6] always 0.
- `z_function_out`  out  32  product from the behavioural multiply function (shared package), same pipeline as `z`.

## Operation
- Input classification:
  - exp=0 means zero; denormals are flushed to zero with their sign kept.
  - exp=255 means infinity; NaN inputs are treated as infinity.
- Sign: `a[31]^b[31]`.
- Special cases. These are exact, so inexact=0.
  - zero×finite gives ±0 (zero=1).
  - inf×finite or inf×inf gives ±inf (inf=1).
  - zero×inf gives 0x7FC00000 (nan=1).
- Normal path, product:
  - Mantissas are `{1,frac}`, 24×24 giving a 48-bit product P.
  - Exponent E = ea+eb−127, 10-bit signed.
  - If P[47]=1: significand is P[47:24], E+1, guard P[23], sticky |P[22:0].
  - Else: significand is P[46:23], guard P[22], sticky |P[21:0].
- Normal path, rounding (inexact = guard|sticky):
  - IEEE_near: increment if guard & (sticky | lsb).
  - IEEE_zero: never increment.
  - IEEE_pinf: increment if inexact & sign=0.
  - IEEE_ninf: increment if inexact & sign=1.
  - near_up: increment if guard & (sticky | sign=0).
  - away_zero: increment if inexact.
  - A 24-bit carry-out shifts the significand right by 1 and adds 1 to E.
- Overflow (E≥255 after rounding): huge=1, inexact=1.
  - Result is ±inf (inf=1) for IEEE_near, near_up and away_zero, for IEEE_pinf when positive, and for IEEE_ninf when negative.
  - All other cases give ±max normal (0x7F7FFFFF magnitude).
- Underflow (E≤0): tiny=1, inexact=1.
  - Result is ±min normal (0x00800000 magnitude) for away_zero, for IEEE_pinf when positive, and for IEEE_ninf when negative.
  - All other cases give ±0 (zero=1).
- Result assembly: `{sign, E[7:0], significand[22:0]}`.
- Flags are not mutually exclusive, e.g. tiny+zero+inexact.
- `z_function_out`:
  - Computed combinationally from the registered operands by the package multiply function, using the same `rnd`.
  - It is registered alongside `z`, so `z_function_out == z` must hold every cycle.

## Timing
- Stage 1: `a` and `b` are registered on the rising edge of `clk`.
- Stage 2: the combinational multiply/round result is registered into `z`, `status` and `z_function_out`.
- Latency is 2 cycles, throughput 1 operation per cycle. There is no handshake and no stall.
- Reset asserted (`rst`=0) asynchronously clears all stage registers. `z`=0, `status`=0 and `z_function_out`=0 for as long as reset is held.
- Reset asserted mid-stream discards in-flight operations.
- After reset deasserts, the first valid output appears 2 rising edges after the first sampled operand.

## Test plan
- Reset held low with random `a`/`b` → `z`, `status` and `z_function_out` stay 0x00000000 / 0x00 / 0x00000000.
- 0x3F000000 × 0x40000000 (0.5×2), IEEE_near → `z`=0x3F800000, `status`=0x00, 2 cycles after input.
- 0x7F000000 × 0x7F000000 → IEEE_near: 0x7F800000 with `status`=0x32. IEEE_zero: 0x7F7FFFFF with `status`=0x30.
- 0x00800000 × 0x00800000 → IEEE_near: 0x00000000 with `status`=0x29. away_zero: 0x00800000 with `status`=0x28.
- Exception grid, all 10×10 pairs of {±NaN, ±inf, ±normal (0xBF214000 / 0x3F2A0000), ±denormal 0x00400000, ±0}:
  - +0×+inf → 0x7FC00000 with `status`=0x04.
  - −inf×+denormal → 0x7FC00000.
  - −NaN×+normal → 0xFF800000 with `status`=0x02.
  - −denormal×−normal → 0x00000000 with `status`=0x01.
- 10000 random `a`/`b` pairs back-to-back, one per cycle → `z == z_function_out` every cycle. Any mismatch is reported with its timestamp.
